pattern_tx: RTL and testbench

Serial frame transmitter that drives the single-bit `x` line consumed by the team's Moore sequence detectors. It accepts a parallel word over a valid/ready handshake and emits a framed bit stream: preamble `0,1` (the edge the "01" detector fires on), data MSB first, then idle-high stop bits. It sits upstream of the detector FSMs and serves as their stimulus source in system-level tests.

---
 rtl/pattern_tx_pkg.sv | 32 +++
 rtl/pattern_tx_piso_shift.sv | 41 ++++
 rtl/pattern_tx.sv | 139 +++++++++++++
 tb/tb_pattern_tx.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/pattern_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pattern_tx_pkg
// Description : Shared constants for the serial pattern transmitter. It holds
//               the state encodings, the default frame geometry that is shared
//               with the detector benches, and the counter-width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package pattern_tx_pkg;

    // 3-bit state encodings
    localparam logic [2:0] c_ST_IDLE = 3'd0;
    localparam logic [2:0] c_ST_PRE0 = 3'd1;
    localparam logic [2:0] c_ST_PRE1 = 3'd2;
    localparam logic [2:0] c_ST_DATA = 3'd3;
    localparam logic [2:0] c_ST_STOP = 3'd4;

    // Default frame geometry, shared with the detector benches
    localparam int c_WIDTH_DEFAULT = 8;
    localparam int c_GAP_DEFAULT   = 2;

    // Bit/stop counter width: clog2 of the larger of WIDTH and GAP, at least 1 bit
    function automatic int cnt_width(input int width, input int gap);
        int m;
        int w;
        m = (width > gap) ? width : gap;
        w = $clog2(m);
        return (w < 1) ? 1 : w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pattern_tx_piso_shift.sv
`default_nettype none
// ============================================================================
// Module      : piso_shift
// Description : WIDTH-bit parallel-in serial-out shift register. It shifts
//               left with zero fill and exposes the current MSB and the MSB
//               that will appear after the next shift.
// Revision    : 1.0 - initial release
// ============================================================================
module piso_shift #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_shift,
    input  logic [WIDTH-1:0] i_din,
    output logic             o_msb,
    output logic             o_next_msb
);

    logic [WIDTH-1:0] r_sr;
    logic [WIDTH-1:0] w_shifted;

    // The shifted value computed once; its MSB feeds the registered serial output
    assign w_shifted  = r_sr << 1;
    assign o_msb      = r_sr[WIDTH-1];
    assign o_next_msb = w_shifted[WIDTH-1];

    // Load has priority over shift; both are idle outside a frame
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sr <= '0;
        end else if (i_load) begin
            r_sr <= i_din;
        end else if (i_shift) begin
            r_sr <= w_shifted;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pattern_tx.sv
`default_nettype none
// ============================================================================
// Module      : pattern_tx
// Description : Serial frame transmitter. A word accepted on load&&ready is
//               sent as preamble 0,1, then the data MSB first, then GAP
//               idle-high stop bits. All outputs are registered.
// Revision    : 1.0 - initial release
// ============================================================================
module pattern_tx
    import pattern_tx_pkg::*;
#(
    parameter int WIDTH = c_WIDTH_DEFAULT,
    parameter int GAP   = c_GAP_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             load,
    output logic             ready,
    output logic             x,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = cnt_width(WIDTH, GAP);
    localparam logic [CNT_W-1:0] c_CNT_DATA = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] c_CNT_STOP = CNT_W'(GAP - 1);

    logic [2:0]       r_state;
    logic [2:0]       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_x;
    logic             r_ready;
    logic             r_busy;
    logic             r_done;
    logic             w_x_nxt;
    logic             w_ready_nxt;
    logic             w_busy_nxt;
    logic             w_done_nxt;
    logic             w_sr_load;
    logic             w_sr_shift;
    logic             w_sr_msb;
    logic             w_sr_next_msb;

    piso_shift #(
        .WIDTH (WIDTH)
    ) u_piso_shift (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_sr_load),
        .i_shift    (w_sr_shift),
        .i_din      (din),
        .o_msb      (w_sr_msb),
        .o_next_msb (w_sr_next_msb)
    );

    assign x     = r_x;
    assign ready = r_ready;
    assign busy  = r_busy;
    assign done  = r_done;

    // State, counter and output registers; outputs are decoded from the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
            r_cnt   <= '0;
            r_x     <= 1'b1;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_x     <= w_x_nxt;
            r_ready <= w_ready_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // Next-state, counter and shift control, plus the next values of the outputs
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_sr_load   = 1'b0;
        w_sr_shift  = 1'b0;
        w_x_nxt     = 1'b1;

        case (r_state)
            c_ST_IDLE: begin
                if (load && r_ready) begin
                    w_sr_load   = 1'b1;
                    w_state_nxt = c_ST_PRE0;
                end
            end
            c_ST_PRE0: begin
                w_state_nxt = c_ST_PRE1;
            end
            c_ST_PRE1: begin
                w_cnt_nxt   = c_CNT_DATA;
                w_state_nxt = c_ST_DATA;
            end
            c_ST_DATA: begin
                w_sr_shift = 1'b1;
                if (r_cnt == '0) begin
                    w_cnt_nxt   = c_CNT_STOP;
                    w_state_nxt = c_ST_STOP;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            c_ST_STOP: begin
                if (r_cnt == '0) begin
                    w_state_nxt = c_ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase

        // The first data bit is the unshifted MSB; later bits are the post-shift MSB
        case (w_state_nxt)
            c_ST_PRE0: w_x_nxt = 1'b0;
            c_ST_DATA: w_x_nxt = (r_state == c_ST_PRE1) ? w_sr_msb : w_sr_next_msb;
            default:   w_x_nxt = 1'b1;
        endcase

        w_ready_nxt = (w_state_nxt == c_ST_IDLE);
        w_busy_nxt  = (w_state_nxt != c_ST_IDLE);
        w_done_nxt  = (w_state_nxt == c_ST_STOP) && (w_cnt_nxt == '0);
    end

endmodule
`default_nettype wire

// File: tb/tb_pattern_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_pattern_tx
// Description : Directed bench for pattern_tx; default geometry instance plus
//               a WIDTH=1, GAP=1 instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pattern_tx;

    logic       clk;
    logic       rst;
    logic       load;
    logic [7:0] din;
    logic       ready;
    logic       x;
    logic       busy;
    logic       done;

    logic       rst1;
    logic       load1;
    logic [0:0] din1;
    logic       ready1;
    logic       x1;
    logic       busy1;
    logic       done1;

    int vectors;
    int miscompares;

    pattern_tx #(.WIDTH(8), .GAP(2)) dut (
        .clk   (clk),
        .rst   (rst),
        .din   (din),
        .load  (load),
        .ready (ready),
        .x     (x),
        .busy  (busy),
        .done  (done)
    );

    pattern_tx #(.WIDTH(1), .GAP(1)) dut1 (
        .clk   (clk),
        .rst   (rst1),
        .din   (din1),
        .load  (load1),
        .ready (ready1),
        .x     (x1),
        .busy  (busy1),
        .done  (done1)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag, input bit sel);
        check({tag, " x"},     sel ? x1     : x,     1);
        check({tag, " ready"}, sel ? ready1 : ready, 1);
        check({tag, " busy"},  sel ? busy1  : busy,  0);
        check({tag, " done"},  sel ? done1  : done,  0);
    endtask

    // Entered in the first frame cycle; exp holds the n frame bits, first bit leftmost
    task automatic check_frame(input string tag, input bit sel, input int n,
                               input logic [15:0] exp, input int exp_rises);
        int   rises = 0;
        logic prev  = 1'b1;
        logic xo;
        for (int i = 0; i < n; i++) begin
            xo = sel ? x1 : x;
            check($sformatf("%s x[%0d]", tag, i),     xo, exp[n-1-i]);
            check($sformatf("%s busy[%0d]", tag, i),  sel ? busy1 : busy, 1);
            check($sformatf("%s ready[%0d]", tag, i), sel ? ready1 : ready, 0);
            check($sformatf("%s done[%0d]", tag, i),  sel ? done1 : done, (i == n - 1) ? 1 : 0);
            if (prev == 1'b0 && xo == 1'b1) rises++;
            prev = xo;
            step();
        end
        check({tag, " 01 count"}, rises, exp_rises);
        check_idle({tag, " after"}, sel);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst   = 1'b1;
        rst1  = 1'b1;
        load  = 1'b0;
        load1 = 1'b0;
        din   = 8'h00;
        din1  = 1'b0;
        step();
        step();
        check_idle("reset", 1'b0);
        check_idle("reset1", 1'b1);
        rst  = 1'b0;
        rst1 = 1'b0;
        step();

        // A5 frame
        load = 1'b1;
        din  = 8'hA5;
        step();
        load = 1'b0;
        check_frame("A5", 1'b0, 12, 16'b0110_1001_0111, 4);

        // All-zero data
        load = 1'b1;
        din  = 8'h00;
        step();
        load = 1'b0;
        check_frame("00", 1'b0, 12, 16'b0100_0000_0011, 2);

        // Back-to-back with load held high; 0F presented during the FF frame
        load = 1'b1;
        din  = 8'hFF;
        step();
        din = 8'h0F;
        check_frame("FF", 1'b0, 12, 16'b0111_1111_1111, 1);
        step();
        load = 1'b0;
        check_frame("0F", 1'b0, 12, 16'b0100_0011_1111, 2);

        // din changes after acceptance
        load = 1'b1;
        din  = 8'hC3;
        step();
        load = 1'b0;
        din  = 8'h3C;
        check_frame("C3", 1'b0, 12, 16'b0111_0000_1111, 2);

        // Reset during data bit 4
        load = 1'b1;
        din  = 8'h00;
        step();
        load = 1'b0;
        for (int i = 0; i < 5; i++) step();
        check("abort in data x", x, 0);
        check("abort in data busy", busy, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_idle("abort", 1'b0);
        for (int i = 0; i < 12; i++) begin
            check($sformatf("abort quiet done[%0d]", i), done, 0);
            check($sformatf("abort quiet x[%0d]", i), x, 1);
            step();
        end
        load = 1'b1;
        din  = 8'h5A;
        step();
        load = 1'b0;
        check_frame("5A", 1'b0, 12, 16'b0101_0110_1011, 5);

        // rst and load on the same edge, both instances
        rst   = 1'b1;
        load  = 1'b1;
        din   = 8'hAA;
        rst1  = 1'b1;
        load1 = 1'b1;
        din1  = 1'b1;
        step();
        rst   = 1'b0;
        load  = 1'b0;
        rst1  = 1'b0;
        load1 = 1'b0;
        check_idle("rst+load", 1'b0);
        check_idle("rst+load1", 1'b1);
        step();
        check_idle("rst+load later", 1'b0);
        check_idle("rst+load1 later", 1'b1);

        // WIDTH=1, GAP=1 frames
        load1 = 1'b1;
        din1  = 1'b1;
        step();
        load1 = 1'b0;
        check_frame("w1 d1", 1'b1, 4, 16'b0111, 1);
        load1 = 1'b1;
        din1  = 1'b0;
        step();
        load1 = 1'b0;
        check_frame("w1 d0", 1'b1, 4, 16'b0101, 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
